stack_ctrl: RTL and testbench
=============================

Name: stack_ctrl

Overview:
Stack pointer and push/pop sequencer that sits directly upstream of the address mux. It owns the stack pointer register, drives the PUSH/POP qualifiers and the stack_pointer address consumed by the mux, and handshakes each stack access with data memory. The stack is empty-descending: SP points at the next free word, and the stack grows toward lower addresses.

Parameters:
DATA_W, 16, memory word and push/pop data width
ADDR_W, 16, address width; must match the mux address width
STACK_TOP, 16'hFFFF, reset SP value; the first push lands here
STACK_DEPTH, 256, maximum number of stacked words (1..65535)
TIMEOUT_CYC, 64, mem_ready watchdog limit; used only with the optional feature

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
push  in  1  push request, sampled in IDLE only
pop  in  1  pop request, sampled in IDLE only
push_data  in  DATA_W  word to push, captured with push
mem_rdata  in  DATA_W  memory read data, valid with mem_ready
mem_ready  in  1  memory completes the current access
clr_err  in  1  clears sticky overflow/underflow/timeout flags
PUSH  out  1  high for the whole write access; to the mux
POP  out  1  high for the whole read access; to the mux
stack_pointer  out  ADDR_W  access address; to the mux
mem_we  out  1  write strobe, equal to PUSH
mem_wdata  out  DATA_W  latched push_data
pop_data  out  DATA_W  last popped word, held until the next pop
done  out  1  one-cycle pulse when an access completes
busy  out  1  high in WRITE or READ
depth  out  16  current number of stacked words
overflow  out  1  sticky: push attempted while full
underflow  out  1  sticky: pop attempted while empty
timeout  out  1  sticky watchdog flag; stays 0 when the feature is compiled out

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State is IDLE; SP=STACK_TOP; depth=0.
  - PUSH, POP, mem_we, done, busy, overflow, underflow and timeout are 0.
  - pop_data=0 and mem_wdata=0.
- A reset asserted mid-access aborts it immediately. SP and depth are not updated, and no done pulse is issued.
- FSM states: IDLE, WRITE, READ. All outputs are registered.
- IDLE:
  - push=1 (push has priority over a simultaneous pop, which is dropped):
    - If depth==STACK_DEPTH: set overflow and stay in IDLE.
    - Otherwise: mem_wdata<=push_data and go to WRITE.
  - pop=1 with push=0:
    - If depth==0: set underflow and stay in IDLE.
    - Otherwise: go to READ.
- WRITE:
  - PUSH=1, mem_we=1, stack_pointer=SP.
  - On a cycle with mem_ready=1: SP<=SP-1, depth<=depth+1, done pulse next cycle, return to IDLE.
- READ:
  - POP=1, stack_pointer=SP+1.
  - On a cycle with mem_ready=1: pop_data<=mem_rdata, SP<=SP+1, depth<=depth-1, done pulse next cycle, return to IDLE.
- Latency: request at edge N gives PUSH/POP high from N+1. The minimum access is 1 cycle, with done at the edge following the one where mem_ready is sampled. Back-to-back requests are accepted from the cycle done is high.
- push/pop received while busy are ignored; no flag is set.
- stack_pointer in IDLE = SP. Address arithmetic is modulo 2^ADDR_W (no saturation). The depth check alone prevents wrap past the stack bounds.
- clr_err=1 clears all sticky flags on the next edge. If clr_err and an error event occur in the same cycle, the set wins.

Optional Feature:
STACK_TIMEOUT_EN
- Defined:
  - A counter runs in WRITE/READ and restarts on entry to either state.
  - If TIMEOUT_CYC cycles elapse without mem_ready: abort to IDLE, set timeout, leave SP/depth/pop_data unchanged, no done pulse.
- Undefined: no counter; timeout is tied to 0, and WRITE/READ wait indefinitely.

Test Plan:
- Reset check -> SP=16'hFFFF, depth=0, all flags/strobes 0.
- Push 16'hA1, 16'hB2, 16'hC3, mem_ready 1 cycle after PUSH -> stack_pointer FFFF, FFFE, FFFD during PUSH; final SP=FFFC; depth=3; 3 done pulses.
- Three pops with mem_rdata echoing the written words -> POP addresses FFFD, FFFE, FFFF; pop_data C3, B2, A1; depth=0.
- STACK_DEPTH=2: 3 pushes -> third push rejected with no PUSH pulse and overflow=1. Then pop on an empty stack -> underflow=1. clr_err -> both flags 0.
- push=pop=1 in IDLE -> only the WRITE executes, depth+1. push asserted while busy -> ignored.
- rst_n low during WRITE, before mem_ready -> PUSH drops at once, SP=STACK_TOP. With STACK_TIMEOUT_EN and TIMEOUT_CYC=4, mem_ready held low -> abort after 4 cycles, timeout=1, SP unchanged.

Source files
------------

// File: rtl/stack_ctrl.sv
// ----------------------------------------------------------------------------
// stack_ctrl
// Stack pointer and push/pop sequencer feeding the address mux. The stack is
// empty-descending: SP points at the next free word and the stack grows toward
// lower addresses. Each accepted push or pop becomes one handshaked access to
// data memory (WRITE or READ state) that completes on mem_ready.
//
// Optional build macro: STACK_TIMEOUT_EN
//   Defined   : a mem_ready watchdog aborts a stalled access after TIMEOUT_CYC
//               cycles and sets the sticky timeout flag.
//   Undefined : no watchdog; timeout is tied to 0 and accesses wait forever.
//
// Ports
//   clk, rst_n     : clock (rising edge), asynchronous active-low reset
//   push, pop      : requests, sampled only while idle (push wins)
//   push_data      : word to push, captured when a push is accepted
//   mem_rdata      : memory read data, valid with mem_ready
//   mem_ready      : memory completes the current access
//   clr_err        : clears the sticky error flags
//   PUSH, POP      : access qualifiers to the mux, high for the whole access
//   stack_pointer  : access address to the mux (SP, or SP+1 while reading)
//   mem_we         : write strobe (same as PUSH)
//   mem_wdata      : latched push word
//   pop_data       : last popped word, held until the next pop completes
//   done           : one-cycle pulse after an access completes
//   busy           : high while an access is in flight
//   depth          : number of stacked words
//   overflow       : sticky, push attempted while full
//   underflow      : sticky, pop attempted while empty
//   timeout        : sticky, watchdog abort (0 when the watchdog is absent)
// ----------------------------------------------------------------------------
module stack_ctrl #(
    parameter int unsigned       DATA_W      = 16,
    parameter int unsigned       ADDR_W      = 16,
    parameter logic [ADDR_W-1:0] STACK_TOP   = 16'hFFFF,
    parameter int unsigned       STACK_DEPTH = 256,
    parameter int unsigned       TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] push_data,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    input  logic              clr_err,
    output logic              PUSH,
    output logic              POP,
    output logic [ADDR_W-1:0] stack_pointer,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] pop_data,
    output logic              done,
    output logic              busy,
    output logic [15:0]       depth,
    output logic              overflow,
    output logic              underflow,
    output logic              timeout
);

    // Elaboration-time sanity checks on the configuration.
    if (STACK_DEPTH < 1 || STACK_DEPTH > 65535) begin : g_bad_depth
        $error("stack_ctrl: STACK_DEPTH must be in 1..65535");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("stack_ctrl: TIMEOUT_CYC must be at least 1");
    end

    localparam logic [15:0] DepthMax = 16'(STACK_DEPTH);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWrite = 2'd1,
        StRead  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] sp_q, sp_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       depth_q, depth_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] pop_data_q, pop_data_d;
    logic              done_q, done_d;
    logic              push_q, push_d;
    logic              pop_q, pop_d;
    logic              busy_q, busy_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;

    // Watchdog expiry for the access in flight (never asserted without the watchdog).
    logic              abort;

`ifdef STACK_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            tmo_q, tmo_d;
    logic            cnt_last;

    // The counter holds 0 in IDLE, so it restarts on every entry to WRITE/READ.
    assign cnt_last = (cnt_q == CntW'(TIMEOUT_CYC - 1));
    assign abort    = (state_q != StIdle) && !mem_ready && cnt_last;

    always_comb begin
        cnt_d = cnt_q;
        tmo_d = tmo_q;
        if (state_q == StIdle) begin
            cnt_d = '0;
        end else if (!cnt_last) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (clr_err) begin
            tmo_d = 1'b0;
        end
        // Setting wins over a same-cycle clear.
        if (abort) begin
            tmo_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end

    assign timeout = tmo_q;
`else
    assign abort   = 1'b0;
    assign timeout = 1'b0;
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        sp_d       = sp_q;
        depth_d    = depth_q;
        wdata_d    = wdata_q;
        pop_data_d = pop_data_q;
        done_d     = 1'b0;
        ovf_d      = ovf_q;
        udf_d      = udf_q;

        if (clr_err) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                // Push takes priority; a simultaneous pop is dropped.
                if (push) begin
                    if (depth_q == DepthMax) begin
                        ovf_d = 1'b1;
                    end else begin
                        wdata_d = push_data;
                        state_d = StWrite;
                    end
                end else if (pop) begin
                    if (depth_q == 16'd0) begin
                        udf_d = 1'b1;
                    end else begin
                        state_d = StRead;
                    end
                end
            end
            StWrite: begin
                if (mem_ready) begin
                    sp_d    = sp_q - 1'b1;
                    depth_d = depth_q + 16'd1;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else if (abort) begin
                    state_d = StIdle;
                end
            end
            StRead: begin
                if (mem_ready) begin
                    pop_data_d = mem_rdata;
                    sp_d       = sp_q + 1'b1;
                    depth_d    = depth_q - 16'd1;
                    done_d     = 1'b1;
                    state_d    = StIdle;
                end else if (abort) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are computed from the next state so they come straight off flops.
        addr_d = (state_d == StRead) ? (sp_d + 1'b1) : sp_d;
        push_d = (state_d == StWrite);
        pop_d  = (state_d == StRead);
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            sp_q       <= STACK_TOP;
            addr_q     <= STACK_TOP;
            depth_q    <= 16'd0;
            wdata_q    <= '0;
            pop_data_q <= '0;
            done_q     <= 1'b0;
            push_q     <= 1'b0;
            pop_q      <= 1'b0;
            busy_q     <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sp_q       <= sp_d;
            addr_q     <= addr_d;
            depth_q    <= depth_d;
            wdata_q    <= wdata_d;
            pop_data_q <= pop_data_d;
            done_q     <= done_d;
            push_q     <= push_d;
            pop_q      <= pop_d;
            busy_q     <= busy_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

    assign PUSH          = push_q;
    assign mem_we        = push_q;
    assign POP           = pop_q;
    assign stack_pointer = addr_q;
    assign mem_wdata     = wdata_q;
    assign pop_data      = pop_data_q;
    assign done          = done_q;
    assign busy          = busy_q;
    assign depth         = depth_q;
    assign overflow      = ovf_q;
    assign underflow     = udf_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// ----------------------------------------------------------------------------
// tb_stack_ctrl
// Scoreboard bench for stack_ctrl. The driver keeps a behavioural stack model
// (a queue of words plus SP/depth/flag values) and, for each accepted request,
// queues the expected completion. A monitor on the falling edge compares the
// DUT status every cycle and pops the scoreboard on each done pulse.
// ----------------------------------------------------------------------------
module tb_stack_ctrl;

    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TMO   = 4;
    localparam logic [15:0] TOP   = 16'hFFFF;

    logic          clk;
    logic          rst_n;
    logic          push;
    logic          pop;
    logic [DW-1:0] push_data;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic          clr_err;
    logic          PUSH;
    logic          POP;
    logic [AW-1:0] stack_pointer;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] pop_data;
    logic          done;
    logic          busy;
    logic [15:0]   depth;
    logic          overflow;
    logic          underflow;
    logic          timeout;

    stack_ctrl #(
        .DATA_W      (DW),
        .ADDR_W      (AW),
        .STACK_TOP   (TOP),
        .STACK_DEPTH (DEPTH),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .push          (push),
        .pop           (pop),
        .push_data     (push_data),
        .mem_rdata     (mem_rdata),
        .mem_ready     (mem_ready),
        .clr_err       (clr_err),
        .PUSH          (PUSH),
        .POP           (POP),
        .stack_pointer (stack_pointer),
        .mem_we        (mem_we),
        .mem_wdata     (mem_wdata),
        .pop_data      (pop_data),
        .done          (done),
        .busy          (busy),
        .depth         (depth),
        .overflow      (overflow),
        .underflow     (underflow),
        .timeout       (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: reads return whatever was stored at the presented address.
    logic [15:0] mem_model [0:65535];
    assign mem_rdata = mem_model[stack_pointer];

    // Reference model.
    logic [15:0] m_stack[$];
    logic [15:0] m_sp;
    int          m_depth;
    logic [15:0] m_wdata;
    logic [15:0] m_pop_data;
    bit          m_ovf, m_udf, m_tmo;
    bit          m_busy, m_read, m_done;

    typedef struct {
        bit          is_push;
        logic [15:0] data;
        logic [15:0] sp;
        int          depth;
    } exp_t;
    exp_t exp_q[$];

    int n_cmp;
    int n_fail;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Monitor: per-cycle status plus scoreboard pop on every done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("done_without_request", 32'(done), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk(e.is_push ? "push_done_pop_data" : "pop_done_pop_data", 32'(pop_data), 32'(e.data));
                chk("done_sp", 32'(stack_pointer), 32'(e.sp));
                chk("done_depth", 32'(depth), 32'(e.depth));
            end
        end
        chk("done", 32'(done), 32'(m_done));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("PUSH", 32'(PUSH), 32'(m_busy && !m_read));
        chk("mem_we", 32'(mem_we), 32'(m_busy && !m_read));
        chk("POP", 32'(POP), 32'(m_busy && m_read));
        chk("stack_pointer", 32'(stack_pointer), 32'((m_busy && m_read) ? m_sp + 16'd1 : m_sp));
        chk("depth", 32'(depth), 32'(m_depth));
        chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
        chk("pop_data", 32'(pop_data), 32'(m_pop_data));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_udf));
        chk("timeout", 32'(timeout), 32'(m_tmo));
    end

    task automatic tick();
        @(posedge clk);
        #1;
        m_done = 1'b0;
    endtask

    task automatic model_reset();
        m_stack.delete();
        exp_q.delete();
        m_sp       = TOP;
        m_depth    = 0;
        m_wdata    = '0;
        m_pop_data = '0;
        m_ovf      = 1'b0;
        m_udf      = 1'b0;
        m_tmo      = 1'b0;
        m_busy     = 1'b0;
        m_read     = 1'b0;
        m_done     = 1'b0;
    endtask

    // Present one request while idle; returns whether an access was started.
    task automatic issue(input bit p, input bit q, input bit c, input logic [15:0] d,
                         output bit accepted);
        exp_t e;
        push      = p;
        pop       = q;
        clr_err   = c;
        push_data = d;
        tick();
        push      = 1'b0;
        pop       = 1'b0;
        clr_err   = 1'b0;
        accepted  = 1'b0;
        if (c) begin
            m_ovf = 1'b0;
            m_udf = 1'b0;
            m_tmo = 1'b0;
        end
        if (p) begin
            if (m_depth == int'(DEPTH)) begin
                m_ovf = 1'b1;
            end else begin
                m_wdata   = d;
                m_busy    = 1'b1;
                m_read    = 1'b0;
                e.is_push = 1'b1;
                e.data    = m_pop_data;
                e.sp      = m_sp - 16'd1;
                e.depth   = m_depth + 1;
                exp_q.push_back(e);
                accepted  = 1'b1;
            end
        end else if (q) begin
            if (m_depth == 0) begin
                m_udf = 1'b1;
            end else begin
                m_busy    = 1'b1;
                m_read    = 1'b1;
                e.is_push = 1'b0;
                e.data    = m_stack[$];
                e.sp      = m_sp + 16'd1;
                e.depth   = m_depth - 1;
                exp_q.push_back(e);
                accepted  = 1'b1;
            end
        end
    endtask

    // Finish the access in flight after 'lat' stall cycles, with random request
    // noise on the inputs that a busy controller must ignore.
    task automatic complete(input int unsigned lat);
        bit c;
        for (int i = 0; i <= int'(lat); i++) begin
            mem_ready = (i == int'(lat));
            push      = 1'($urandom_range(0, 1));
            pop       = 1'($urandom_range(0, 1));
            push_data = 16'($urandom);
            c         = ($urandom_range(0, 3) == 0);
            clr_err   = c;
            tick();
            if (c) begin
                m_ovf = 1'b0;
                m_udf = 1'b0;
                m_tmo = 1'b0;
            end
        end
        mem_ready = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        clr_err   = 1'b0;
        if (!m_read) begin
            mem_model[m_sp] = m_wdata;
            m_stack.push_back(m_wdata);
            m_sp    = m_sp - 16'd1;
            m_depth = m_depth + 1;
        end else begin
            m_pop_data = m_stack.pop_back();
            m_sp       = m_sp + 16'd1;
            m_depth    = m_depth - 1;
        end
        m_busy = 1'b0;
        m_done = 1'b1;
    endtask

    task automatic cmd(input bit p, input bit q, input bit c, input logic [15:0] d,
                       input int unsigned lat);
        bit acc;
        issue(p, q, c, d, acc);
        if (acc) begin
            complete(lat);
        end
    endtask

    initial begin
        bit acc;
        int unsigned r;
        n_cmp     = 0;
        n_fail    = 0;
        push      = 1'b0;
        pop       = 1'b0;
        clr_err   = 1'b0;
        push_data = '0;
        mem_ready = 1'b0;
        rst_n     = 1'b0;
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Three pushes then three pops, memory answering one cycle into each access.
        cmd(1'b1, 1'b0, 1'b0, 16'h00A1, 1);
        cmd(1'b1, 1'b0, 1'b0, 16'h00B2, 1);
        cmd(1'b1, 1'b0, 1'b0, 16'h00C3, 1);
        chk("sp_after_3_pushes", 32'(stack_pointer), 32'h0000_FFFC);
        for (int i = 0; i < 3; i++) cmd(1'b0, 1'b1, 1'b0, 16'h0000, 1);
        chk("pop_data_last", 32'(pop_data), 32'h0000_00A1);

        // Fill, overflow, drain, underflow, clear.
        for (int i = 0; i < int'(DEPTH); i++) cmd(1'b1, 1'b0, 1'b0, 16'($urandom), $urandom_range(0, 3));
        cmd(1'b1, 1'b0, 1'b0, 16'h1234, 0);
        for (int i = 0; i < int'(DEPTH); i++) cmd(1'b0, 1'b1, 1'b0, 16'h0000, $urandom_range(0, 3));
        cmd(1'b0, 1'b1, 1'b0, 16'h0000, 0);
        cmd(1'b0, 1'b0, 1'b1, 16'h0000, 0);
        // An error in the same cycle as clr_err stays set.
        cmd(1'b0, 1'b1, 1'b1, 16'h0000, 0);
        cmd(1'b0, 1'b0, 1'b1, 16'h0000, 0);

        // Simultaneous push and pop: only the push runs.
        cmd(1'b1, 1'b1, 1'b0, 16'h5A5A, 2);
        cmd(1'b0, 1'b1, 1'b0, 16'h0000, 0);

        // Randomized traffic with idle gaps and back-to-back requests.
        repeat (400) begin
            r = $urandom_range(0, 9);
            cmd(r < 5, (r >= 3) && (r < 9), (r == 9) || ($urandom_range(0, 7) == 0),
                16'($urandom), $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) tick();
        end

        // Reset during a stalled write aborts it with no done pulse.
        while (m_depth == int'(DEPTH)) cmd(1'b0, 1'b1, 1'b0, 16'h0000, 0);
        issue(1'b1, 1'b0, 1'b0, 16'hBEEF, acc);
        tick();
        rst_n = 1'b0;
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        cmd(1'b1, 1'b0, 1'b0, 16'h0777, 0);

`ifdef STACK_TIMEOUT_EN
        // Stalled access is abandoned after TMO cycles; SP/depth stay put.
        issue(1'b1, 1'b0, 1'b0, 16'hDEAD, acc);
        for (int i = 0; i < int'(TMO); i++) tick();
        m_busy = 1'b0;
        m_tmo  = 1'b1;
        void'(exp_q.pop_back());
        tick();
        issue(1'b0, 1'b1, 1'b0, 16'h0000, acc);
        for (int i = 0; i < int'(TMO); i++) tick();
        m_busy = 1'b0;
        m_tmo  = 1'b1;
        void'(exp_q.pop_back());
        tick();
        cmd(1'b0, 1'b0, 1'b1, 16'h0000, 0);
        cmd(1'b0, 1'b1, 1'b0, 16'h0000, 3);
`endif

        tick();
        tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
